// File: rtl/bk_sd_ctrl.sv
// bk_sd_ctrl: backup-RAM load/save sequencer.
// Moves the BSRAM image to and from the mounted save file, one 512-byte sector
// at a time, over the hps_io SD sector handshake. It loads the image
// automatically after each ROM download, tracks unsaved core writes, and gives
// up with a sticky error if hps_io never acknowledges a request.
module bk_sd_ctrl #(
    parameter int unsigned TIMEOUT = 2000000,
    parameter int unsigned LBA_W   = 32
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ioctl_download,
    input  logic             img_mounted,
    input  logic             img_readonly,
    input  logic [63:0]      img_size,
    input  logic [23:0]      ram_mask,
    input  logic             bk_load,
    input  logic             bk_save,
    input  logic             bsram_wr,
    input  logic             sd_ack,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    output logic             bk_loading,
    output logic             bk_busy,
    output logic             bk_ena,
    output logic             bk_dirty,
    output logic             bk_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [LBA_W-1:0] lba_nxt;
    logic             rd_nxt, wr_nxt, loading_nxt, err_nxt;

    // Input levels from the previous cycle, plus the registered edge pulses.
    logic dl_q, load_q, save_q, ack_q;
    logic dl_rise, dl_fall, load_rise, save_rise, ack_rise, ack_fall;
    logic load_lvl, save_lvl;

    // Index of the last sector in the image. Bits below 512 bytes drop out,
    // so any mask under 512 gives a single sector.
    logic [LBA_W-1:0] last_lba;

    assign load_lvl = bk_load & bk_ena;
    assign save_lvl = bk_save & bk_ena;
    assign last_lba = LBA_W'(ram_mask >> 9);
    assign bk_busy  = (state != ST_IDLE);

    // Edge detectors. The edge pulse is registered, so an edge takes effect
    // one cycle after it appears on the input.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q      <= 1'b0;
            load_q    <= 1'b0;
            save_q    <= 1'b0;
            ack_q     <= 1'b0;
            dl_rise   <= 1'b0;
            dl_fall   <= 1'b0;
            load_rise <= 1'b0;
            save_rise <= 1'b0;
            ack_rise  <= 1'b0;
            ack_fall  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // right-hand side here reads the value from before this clock edge.
            dl_q      <= ioctl_download;
            load_q    <= load_lvl;
            save_q    <= save_lvl;
            ack_q     <= sd_ack;
            dl_rise   <= ioctl_download & ~dl_q;
            dl_fall   <= ~ioctl_download & dl_q;
            load_rise <= load_lvl & ~load_q;
            save_rise <= save_lvl & ~save_q;
            ack_rise  <= sd_ack & ~ack_q;
            ack_fall  <= ~sd_ack & ack_q;
        end
    end

    // A save image is usable once a writable, non-empty file is mounted during
    // a download. Each new download forgets the previous image.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bk_ena <= 1'b0;
        end else if (dl_rise) begin
            bk_ena <= 1'b0;
        end else if (ioctl_download && img_mounted && (img_size != 64'd0) && !img_readonly) begin
            bk_ena <= 1'b1;
        end
    end

    // Unsaved-change flag. Writes during a load are the load itself, so they
    // are not counted. A completed transfer or a new download clears the flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bk_dirty <= 1'b0;
        end else if ((state == ST_DONE) || dl_rise) begin
            bk_dirty <= 1'b0;
        end else if (bsram_wr && !bk_loading) begin
            bk_dirty <= 1'b1;
        end
    end

    // Sequencer state and its registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sd_lba     <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_loading <= 1'b0;
            bk_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sd_lba     <= lba_nxt;
            sd_rd      <= rd_nxt;
            sd_wr      <= wr_nxt;
            bk_loading <= loading_nxt;
            bk_err     <= err_nxt;
        end
    end

    // Next state and outputs: start a transfer, issue a request per sector,
    // wait for the acknowledge, and abort on a timeout or a new download.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves a value unassigned and no latch is inferred.
        state_nxt   = state;
        cnt_nxt     = cnt;
        lba_nxt     = sd_lba;
        rd_nxt      = sd_rd;
        wr_nxt      = sd_wr;
        loading_nxt = bk_loading;
        err_nxt     = bk_err;

        if (dl_rise && (state != ST_IDLE)) begin
            // A new download invalidates the image; stop quietly.
            state_nxt   = ST_IDLE;
            rd_nxt      = 1'b0;
            wr_nxt      = 1'b0;
            loading_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_rise || (dl_fall && bk_ena)) begin
                        state_nxt   = ST_REQ;
                        cnt_nxt     = '0;
                        lba_nxt     = '0;
                        err_nxt     = 1'b0;
                        loading_nxt = 1'b1;
                        rd_nxt      = 1'b1;
                    end else if (save_rise) begin
                        state_nxt   = ST_REQ;
                        cnt_nxt     = '0;
                        lba_nxt     = '0;
                        err_nxt     = 1'b0;
                        loading_nxt = 1'b0;
                        wr_nxt      = 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack_rise) begin
                        state_nxt = ST_XFER;
                        rd_nxt    = 1'b0;
                        wr_nxt    = 1'b0;
                    end else if (cnt >= CNT_W'(TIMEOUT - 1)) begin
                        state_nxt   = ST_IDLE;
                        rd_nxt      = 1'b0;
                        wr_nxt      = 1'b0;
                        loading_nxt = 1'b0;
                        err_nxt     = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (ack_fall) begin
                        if (sd_lba >= last_lba) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_REQ;
                            lba_nxt   = sd_lba + LBA_W'(1);
                            rd_nxt    = bk_loading;
                            wr_nxt    = ~bk_loading;
                            cnt_nxt   = '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt   = ST_IDLE;
                    loading_nxt = 1'b0;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bk_sd_ctrl.sv
// tb_bk_sd_ctrl: directed plus randomized bench for bk_sd_ctrl.
// An hps_io stand-in answers every sector request after a random delay and
// logs what was asked. Each transfer is then compared against the sector list
// the image size implies.
module tb_bk_sd_ctrl;

    localparam int unsigned TO = 100;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic [63:0] img_size = 64'd0;
    logic [23:0] ram_mask = 24'h001FFF;
    logic        bk_load = 1'b0;
    logic        bk_save = 1'b0;
    logic        bsram_wr = 1'b0;
    logic        sd_ack = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, bk_loading, bk_busy, bk_ena, bk_dirty, bk_err;

    bk_sd_ctrl #(.TIMEOUT(TO), .LBA_W(32)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .img_mounted   (img_mounted),
        .img_readonly  (img_readonly),
        .img_size      (img_size),
        .ram_mask      (ram_mask),
        .bk_load       (bk_load),
        .bk_save       (bk_save),
        .bsram_wr      (bsram_wr),
        .sd_ack        (sd_ack),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .bk_loading    (bk_loading),
        .bk_busy       (bk_busy),
        .bk_ena        (bk_ena),
        .bk_dirty      (bk_dirty),
        .bk_err        (bk_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [31:0] lba;
        logic        wr;
        logic        both;
        logic        loading;
    } xfer_t;

    xfer_t xq[$];
    bit    hps_en = 1'b1;
    int    passed = 0;
    int    total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // hps_io stand-in: logs each request, then acknowledges it with a random
    // delay and a random pulse width.
    initial begin : hps_model
        xfer_t r;
        forever begin
            @(negedge clk_sys);
            if (hps_en && reset_n && (sd_rd || sd_wr)) begin
                r.lba     = sd_lba;
                r.wr      = sd_wr;
                r.both    = sd_rd & sd_wr;
                r.loading = bk_loading;
                xq.push_back(r);
                repeat ($urandom_range(0, 5)) @(negedge clk_sys);
                sd_ack = 1'b1;
                repeat ($urandom_range(1, 5)) @(negedge clk_sys);
                sd_ack = 1'b0;
                @(negedge clk_sys);
            end
        end
    end

    task automatic pulse_req(input bit ld, input bit sv);
        @(negedge clk_sys);
        bk_load = ld;
        bk_save = sv;
        repeat (2) @(negedge clk_sys);
        bk_load = 1'b0;
        bk_save = 1'b0;
    endtask

    task automatic mount(input bit ro);
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        repeat (4) @(negedge clk_sys);
        img_readonly = ro;
        img_size     = 64'd8192;
        img_mounted  = 1'b1;
        @(negedge clk_sys);
        img_mounted  = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    // Wait for a transfer to start and finish. Then compare the logged
    // requests with sectors 0..sectors-1 in the expected direction.
    task automatic run_xfer(input string tag, input bit is_save, input int sectors, input bit poke);
        bit seen, done, mid_done;
        seen = bk_busy;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_sys);
            seen = bk_busy;
        end
        check({tag, "_start"}, 64'(seen), 64'd1);
        done = 1'b0;
        mid_done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk_sys);
            bsram_wr = poke & bk_loading;
            if (poke && !mid_done && xq.size() >= 2) begin
                mid_done = 1'b1;
                check({tag, "_dirty_mid_load"}, 64'(bk_dirty), 64'd0);
            end
            done = !bk_busy;
        end
        bsram_wr = 1'b0;
        check({tag, "_end"}, 64'(done), 64'd1);
        check({tag, "_count"}, 64'(xq.size()), 64'(sectors));
        for (int i = 0; i < xq.size(); i++)
            check($sformatf("%s_x%0d", tag, i),
                  64'({xq[i].lba, xq[i].wr, xq[i].both, xq[i].loading}),
                  64'({32'(i), is_save, 1'b0, ~is_save}));
        check({tag, "_idle"}, 64'({sd_rd, sd_wr, bk_loading, bk_err, bk_dirty}), 64'd0);
        xq.delete();
    endtask

    initial begin : stim
        int n, s;
        bit ok, op;

        // Reset state
        #12;
        check("reset_outputs",
              64'({sd_lba, sd_rd, sd_wr, bk_loading, bk_busy, bk_ena, bk_dirty, bk_err}), 64'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Auto-load of an 8 KB image after a download; core writes during the
        // load must not mark the RAM dirty.
        ram_mask = 24'h001FFF;
        mount(1'b0);
        check("ena_after_mount", 64'(bk_ena), 64'd1);
        ioctl_download = 1'b0;
        run_xfer("autoload", 1'b0, 16, 1'b1);

        // A write while idle marks the RAM dirty; a 2 KB save clears it.
        ram_mask = 24'h0007FF;
        @(negedge clk_sys);
        bsram_wr = 1'b1;
        @(negedge clk_sys);
        bsram_wr = 1'b0;
        @(negedge clk_sys);
        check("dirty_idle_write", 64'(bk_dirty), 64'd1);
        pulse_req(1'b0, 1'b1);
        run_xfer("save2k", 1'b1, 4, 1'b0);

        // Load and save in the same cycle: the load wins. A save edge during
        // the load is dropped, not queued.
        ram_mask = 24'h001FFF;
        @(negedge clk_sys);
        bk_load = 1'b1;
        bk_save = 1'b1;
        repeat (4) @(negedge clk_sys);
        bk_save = 1'b0;
        repeat (2) @(negedge clk_sys);
        bk_save = 1'b1;
        run_xfer("both_edges", 1'b0, 16, 1'b0);
        repeat (20) @(negedge clk_sys);
        check("save_not_queued", 64'({bk_busy, 32'(xq.size())}), 64'd0);
        bk_load = 1'b0;
        bk_save = 1'b0;

        // Random image sizes, including masks under one sector, and random direction.
        for (int k = 0; k < 6; k++) begin
            s = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(1, 8));
            ram_mask = 24'(((s - 1) << 9) | int'($urandom_range(0, 511)));
            op = 1'($urandom_range(0, 1));
            if (op) begin
                @(negedge clk_sys);
                bsram_wr = 1'b1;
                @(negedge clk_sys);
                bsram_wr = 1'b0;
            end
            pulse_req(~op, op);
            run_xfer($sformatf("rand%0d", k), op, (int'(ram_mask) >> 9) + 1, 1'b0);
        end

        // Timeout: no acknowledge, so the read must stay up exactly TO cycles.
        hps_en = 1'b0;
        pulse_req(1'b1, 1'b0);
        ok = sd_rd;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_sys);
            ok = sd_rd;
        end
        check("timeout_rd_seen", 64'(ok), 64'd1);
        n = 0;
        while (sd_rd && n < 3 * TO) begin
            @(negedge clk_sys);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(TO));
        check("timeout_flags", 64'({bk_err, bk_busy, bk_loading}), 64'b100);
        hps_en = 1'b1;
        xq.delete();
        ram_mask = 24'h0003FF;
        pulse_req(1'b1, 1'b0);
        run_xfer("after_timeout", 1'b0, 2, 1'b0);

        // A new download aborts a save in progress without raising an error.
        ram_mask = 24'h001FFF;
        pulse_req(1'b0, 1'b1);
        bsram_wr = 1'b1;
        @(negedge clk_sys);
        bsram_wr = 1'b0;
        for (int i = 0; i < 100 && xq.size() < 2; i++) @(negedge clk_sys);
        check("abort_mid_save", 64'({bk_busy, bk_dirty}), 64'b11);
        ioctl_download = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("abort_result",
              64'({bk_busy, sd_rd, sd_wr, bk_loading, bk_err, bk_dirty, bk_ena}), 64'd0);

        // A read-only image: no auto-load, and requests are ignored.
        repeat (2) @(negedge clk_sys);
        img_readonly = 1'b1;
        img_mounted  = 1'b1;
        @(negedge clk_sys);
        img_mounted  = 1'b0;
        repeat (2) @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (10) @(negedge clk_sys);
        xq.delete();
        check("readonly_ena", 64'({bk_ena, bk_busy}), 64'd0);
        pulse_req(1'b1, 1'b1);
        pulse_req(1'b0, 1'b1);
        repeat (20) @(negedge clk_sys);
        check("readonly_no_req", 64'({32'(xq.size()), sd_rd, sd_wr, bk_busy}), 64'd0);

        // Reset in the middle of a save clears every output at once.
        mount(1'b0);
        ioctl_download = 1'b0;
        run_xfer("reload", 1'b0, 16, 1'b0);
        pulse_req(1'b0, 1'b1);
        for (int i = 0; i < 100 && xq.size() < 3; i++) @(negedge clk_sys);
        check("presave_busy", 64'(bk_busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_save",
              64'({sd_lba, sd_rd, sd_wr, bk_loading, bk_busy, bk_ena, bk_dirty, bk_err}), 64'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (15) @(negedge clk_sys);
        check("post_reset_idle", 64'({bk_busy, sd_rd, sd_wr}), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
